qblock_array_handler: RTL and testbench
=======================================

# qblock_array_handler

Parametrised question-block manager for the race game: tracks `NUM_BLOCKS` Q-blocks against `NUM_CARS` cars and detects circle-overlap pickups. Arbitrates simultaneous pickups, hides and respawns each block on its own timer, and delivers a random item code to each car over a valid/ready handshake. Sits in the game-control layer between car physics (positions, radii) and the item/renderer logic (display flags, item consumption).

## Interface
- `NUM_BLOCKS`, default 4: number of Q-blocks (1..8).
- `NUM_CARS`, default 2: number of cars (1..4).
- `POS_W`, default 16: signed fixed-point map coordinate width, including fraction bits.
- `FRAC_W`, default 4: fraction bits of the coordinates.
- `RAD_W`, default 8: unsigned integer radius width.
- `FRAME_RATE`, default 60: render-clock ticks per second.
- `REGEN_SEC`, default 3: seconds a block stays hidden after pickup.
- `ITEM_W`, default 2: item code width.

Ports:
- `i_render_clk` in, 1: render clock, one tick per frame. Single clock domain.
- `i_rst_n` in, 1: asynchronous, active-low reset.
- `i_car_x`, `i_car_y` in, `NUM_CARS*POS_W`: packed signed car centres; car c is at `[c*POS_W +: POS_W]`.
- `i_car_r` in, `NUM_CARS*RAD_W`: car radii.
- `i_blk_x`, `i_blk_y` in, `NUM_BLOCKS*POS_W`: packed signed block centres.
- `i_blk_r` in, `NUM_BLOCKS*RAD_W`: block radii.
- `i_item_ready` in, `NUM_CARS`: car c consumes its pending item.
- `o_display` out, `NUM_BLOCKS`: block visible (drawn by the renderer).
- `o_item_valid` out, `NUM_CARS`: item pending for car c.
- `o_item_code` out, `NUM_CARS*ITEM_W`: pending item code.
- `o_pickup` out, `NUM_BLOCKS`: one-cycle pulse when block b is collected.

## Operation
- **Per-block FSM:** `DISPLAY` and `HIDE`.
  - `DISPLAY` to `HIDE` when the block is granted to a car.
  - `HIDE` to `DISPLAY` when `timer == REGEN_SEC*FRAME_RATE-1`.
  - Timer width is `$clog2(REGEN_SEC*FRAME_RATE)`. It is cleared in `DISPLAY` and increments every cycle in `HIDE`.
- **Hit test (combinational, per pair):**
  - `dx = car_x - blk_x` and `dy = car_y - blk_y`, computed at `POS_W+1` bits signed.
  - `rs = (car_r + blk_r) << FRAC_W`, computed at `RAD_W+1+FRAC_W` bits.
  - Squares and sum are computed at `2*(POS_W+1)+1` bits, with no truncation.
  - `hit = (dx²+dy² <= rs²)`, so tangency counts as a hit.
  - `hit` is qualified by block state `DISPLAY`.
- **Eligibility:** car c is eligible when `!o_item_valid[c] || i_item_ready[c]`. A car holding an unconsumed item cannot collect, and the block stays displayed.
- **Arbitration:**
  - Per block, the winner is the first eligible hitting car searching upward from `rr_ptr`, with modulo `NUM_CARS` wrap.
  - A car wins at most one block per cycle; the lowest block index has priority, and losing blocks stay `DISPLAY`.
  - `rr_ptr` is updated to `(last winning car + 1) mod NUM_CARS` when any grant occurs, and is otherwise unchanged.
- **Item generation:**
  - 8-bit free-running Galois LFSR with taps x^8+x^6+x^5+x^4+1, seed `8'hA5`, advancing every cycle.
  - The granted car receives `lfsr[ITEM_W-1:0]` (current value); simultaneous winners receive identical codes.
- **Handshake:**
  - Valid and ready at an edge consumes the item.
  - If a new grant arrives on the same edge, valid stays 1 and the new code loads.
  - Otherwise valid clears, and the code holds its value.

## Timing
- Reset values:
  - all blocks `DISPLAY`, so `o_display` is all 1;
  - timers 0, `o_item_valid` 0, `o_item_code` 0, `o_pickup` 0;
  - `rr_ptr` 0, LFSR `8'hA5`.
- Latency from inputs to a hit is 1 cycle. Inputs sampled at edge k drive `o_display` low, `o_pickup` high, `o_item_valid` high and the loaded code at k+1.
- A block is hidden for exactly `REGEN_SEC*FRAME_RATE` cycles, then it can be collected again on the first cycle of `DISPLAY`.
- `o_pickup` lasts exactly one cycle per grant.
- Reset asserted mid-`HIDE` or with an item pending returns everything to the reset values immediately (asynchronous reset).

## Configuration
- `QBLOCK_RESPAWN_BLINK_EN` defined:
  - during the last `FRAME_RATE` cycles of `HIDE`, `o_display[b] = timer[3]`, giving a warning blink;
  - the block is still not collectible until `DISPLAY`.
- Undefined: `o_display[b]` is 1 only in `DISPLAY`.

## Test plan
- **Single pickup:** car0 at (100,100) integer, block0 at (104,100), radii 3 and 2 → `o_pickup[0]` and `o_item_valid[0]` at k+1; `o_display[0]` low for 180 cycles, high on cycle 181.
- **Tangency boundary:** dx = 5.0 with radius sum 5 → hit; dx = 5.0625 (one LSB more) → no hit.
- **Simultaneous contention:** both cars overlap block0 at `rr_ptr`=0 → car0 wins; repeat after respawn → car1 wins (round-robin); the losing car's valid stays 0.
- **Pending item blocks pickup:** car0 valid=1, ready=0, overlaps block1 → block1 stays displayed; raise ready → consumed, then pickup on the following edge.
- **Ready and new grant on the same edge:** valid stays 1 and the code updates to the current LFSR bits.
- **Reset mid-HIDE:** assert `i_rst_n`=0 at timer 50 → all outputs return to reset values asynchronously; with the blink macro defined, `o_display` toggles every 8 cycles during timer 120..179.

Source files
------------

// File: rtl/qblock_array_handler.sv
// qblock_array_handler
//   Question-block manager for the race game. Tracks NUM_BLOCKS Q-blocks
//   against NUM_CARS cars, detects circle-overlap pickups, arbitrates
//   simultaneous pickups round-robin, hides each block for
//   REGEN_SEC*FRAME_RATE frames after pickup, and hands a pseudo-random
//   item code to the collecting car over a valid/ready handshake.
//
// Ports
//   i_render_clk        render clock, one tick per frame
//   i_rst_n             asynchronous active-low reset
//   i_car_x/i_car_y     packed signed car centres (POS_W each, FRAC_W frac)
//   i_car_r             packed unsigned car radii (integer units)
//   i_blk_x/i_blk_y     packed signed block centres
//   i_blk_r             packed unsigned block radii
//   i_item_ready        per-car item consume strobe
//   o_display           per-block visible flag
//   o_item_valid        per-car item pending
//   o_item_code         per-car pending item code
//   o_pickup            per-block one-cycle pickup pulse
//
// Build option
//   QBLOCK_RESPAWN_BLINK_EN : blink a hidden block during its last
//   FRAME_RATE frames (o_display follows timer bit 3). The block is still
//   not collectible until it returns to DISPLAY.
module qblock_array_handler #(
  parameter int NUM_BLOCKS = 4,
  parameter int NUM_CARS   = 2,
  parameter int POS_W      = 16,
  parameter int FRAC_W     = 4,
  parameter int RAD_W      = 8,
  parameter int FRAME_RATE = 60,
  parameter int REGEN_SEC  = 3,
  parameter int ITEM_W     = 2
) (
  input  logic                         i_render_clk,
  input  logic                         i_rst_n,
  input  logic [NUM_CARS*POS_W-1:0]    i_car_x,
  input  logic [NUM_CARS*POS_W-1:0]    i_car_y,
  input  logic [NUM_CARS*RAD_W-1:0]    i_car_r,
  input  logic [NUM_BLOCKS*POS_W-1:0]  i_blk_x,
  input  logic [NUM_BLOCKS*POS_W-1:0]  i_blk_y,
  input  logic [NUM_BLOCKS*RAD_W-1:0]  i_blk_r,
  input  logic [NUM_CARS-1:0]          i_item_ready,
  output logic [NUM_BLOCKS-1:0]        o_display,
  output logic [NUM_CARS-1:0]          o_item_valid,
  output logic [NUM_CARS*ITEM_W-1:0]   o_item_code,
  output logic [NUM_BLOCKS-1:0]        o_pickup
);

  localparam int HIDE_CYC = REGEN_SEC * FRAME_RATE;
  localparam int TMR_W    = $clog2(HIDE_CYC);
  localparam int CAR_W    = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1;
  localparam int D_W      = POS_W + 1;
  localparam int RS_W     = RAD_W + 1 + FRAC_W;
  localparam int SQ_W     = 2 * D_W + 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(HIDE_CYC - 1);

  typedef enum logic {DISPLAY = 1'b0, HIDE = 1'b1} blk_state_e;

  blk_state_e                  state_q [NUM_BLOCKS];
  logic [TMR_W-1:0]            timer_q [NUM_BLOCKS];
  logic [CAR_W-1:0]            rr_ptr_q, rr_ptr_d;
  logic [7:0]                  lfsr_q, lfsr_d;
  logic [NUM_CARS-1:0]         valid_q, valid_d;
  logic [NUM_CARS*ITEM_W-1:0]  code_q, code_d;
  logic [NUM_BLOCKS-1:0]       pickup_q;

  logic [NUM_BLOCKS*NUM_CARS-1:0] hit;
  logic [NUM_CARS-1:0]            eligible;
  logic [NUM_BLOCKS-1:0]          grant_blk;
  logic [NUM_CARS-1:0]            grant_car;

  // Hit test per (block, car): exact squared-distance compare, no truncation.
  for (genvar b = 0; b < NUM_BLOCKS; b++) begin : g_blk
    for (genvar c = 0; c < NUM_CARS; c++) begin : g_car
      logic signed [D_W-1:0]  dx, dy;
      logic signed [SQ_W-1:0] dx_e, dy_e;
      logic [RS_W-1:0]        rs;
      logic [SQ_W-1:0]        dist2, rs2;

      assign dx = $signed({i_car_x[c*POS_W+POS_W-1], i_car_x[c*POS_W +: POS_W]})
                - $signed({i_blk_x[b*POS_W+POS_W-1], i_blk_x[b*POS_W +: POS_W]});
      assign dy = $signed({i_car_y[c*POS_W+POS_W-1], i_car_y[c*POS_W +: POS_W]})
                - $signed({i_blk_y[b*POS_W+POS_W-1], i_blk_y[b*POS_W +: POS_W]});
      assign dx_e  = SQ_W'(dx);
      assign dy_e  = SQ_W'(dy);
      assign dist2 = $unsigned(dx_e * dx_e + dy_e * dy_e);
      // Radii are integers; shift them into the coordinate fixed-point scale.
      assign rs  = (RS_W'(i_car_r[c*RAD_W +: RAD_W]) + RS_W'(i_blk_r[b*RAD_W +: RAD_W])) << FRAC_W;
      assign rs2 = SQ_W'(rs) * SQ_W'(rs);
      assign hit[b*NUM_CARS+c] = (state_q[b] == DISPLAY) && (dist2 <= rs2);
    end
  end

  // A car holding an unconsumed item may only collect if it consumes now.
  assign eligible = ~valid_q | i_item_ready;

  // Lowest block first; each block scans cars upward from rr_ptr. A car
  // already granted this cycle is skipped so it wins at most one block.
  always_comb begin
    int c;
    c         = 0;
    grant_blk = '0;
    grant_car = '0;
    rr_ptr_d  = rr_ptr_q;
    for (int b = 0; b < NUM_BLOCKS; b++) begin
      for (int k = 0; k < NUM_CARS; k++) begin
        c = int'(rr_ptr_q) + k;
        if (c >= NUM_CARS) c = c - NUM_CARS;
        if (!grant_blk[b] && hit[b*NUM_CARS+c] && eligible[c] && !grant_car[c]) begin
          grant_blk[b] = 1'b1;
          grant_car[c] = 1'b1;
          rr_ptr_d     = CAR_W'((c + 1) % NUM_CARS);
        end
      end
    end
  end

  // A new grant overrides a same-edge consume; otherwise ready clears valid.
  always_comb begin
    valid_d = valid_q;
    code_d  = code_q;
    for (int c = 0; c < NUM_CARS; c++) begin
      if (grant_car[c]) begin
        valid_d[c]                  = 1'b1;
        code_d[c*ITEM_W +: ITEM_W]  = lfsr_q[ITEM_W-1:0];
      end else if (i_item_ready[c]) begin
        valid_d[c] = 1'b0;
      end
    end
  end

  // Right-shifting Galois LFSR, polynomial x^8+x^6+x^5+x^4+1.
  assign lfsr_d = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);

  always_ff @(posedge i_render_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int b = 0; b < NUM_BLOCKS; b++) begin
        state_q[b] <= DISPLAY;
        timer_q[b] <= '0;
      end
      rr_ptr_q <= '0;
      lfsr_q   <= 8'hA5;
      valid_q  <= '0;
      code_q   <= '0;
      pickup_q <= '0;
    end else begin
      for (int b = 0; b < NUM_BLOCKS; b++) begin
        case (state_q[b])
          DISPLAY: begin
            timer_q[b] <= '0;
            if (grant_blk[b]) state_q[b] <= HIDE;
          end
          HIDE: begin
            if (timer_q[b] == TMR_LAST) begin
              state_q[b] <= DISPLAY;
              timer_q[b] <= '0;
            end else begin
              timer_q[b] <= timer_q[b] + 1'b1;
            end
          end
        endcase
      end
      rr_ptr_q <= rr_ptr_d;
      lfsr_q   <= lfsr_d;
      valid_q  <= valid_d;
      code_q   <= code_d;
      pickup_q <= grant_blk;
    end
  end

`ifdef QBLOCK_RESPAWN_BLINK_EN
  localparam logic [TMR_W-1:0] BLINK_START = TMR_W'(HIDE_CYC - FRAME_RATE);
`endif

  always_comb begin
    o_display = '0;
    for (int b = 0; b < NUM_BLOCKS; b++) begin
`ifdef QBLOCK_RESPAWN_BLINK_EN
      o_display[b] = (state_q[b] == DISPLAY) ||
                     ((timer_q[b] >= BLINK_START) && timer_q[b][3]);
`else
      o_display[b] = (state_q[b] == DISPLAY);
`endif
    end
  end

  assign o_item_valid = valid_q;
  assign o_item_code  = code_q;
  assign o_pickup     = pickup_q;

endmodule

// File: tb/tb_qblock_array_handler.sv
// Testbench for qblock_array_handler: directed scenarios plus randomized
// car placement, all checked against a behavioural model of blocks,
// cars, round-robin pointer and item LFSR.
module tb_qblock_array_handler;

  localparam int NB     = 4;
  localparam int NC     = 2;
  localparam int POS_W  = 16;
  localparam int FRAC_W = 4;
  localparam int RAD_W  = 8;
  localparam int FR     = 60;
  localparam int RS     = 3;
  localparam int IW     = 2;
  localparam int HIDE   = RS * FR;
  localparam int VEC_W  = 2*NB + NC + NC*IW;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NC*POS_W-1:0]   car_x, car_y;
  logic [NC*RAD_W-1:0]   car_r;
  logic [NB*POS_W-1:0]   blk_x, blk_y;
  logic [NB*RAD_W-1:0]   blk_r;
  logic [NC-1:0]         ready;
  logic [NB-1:0]         o_display, o_pickup;
  logic [NC-1:0]         o_item_valid;
  logic [NC*IW-1:0]      o_item_code;

  qblock_array_handler #(
    .NUM_BLOCKS(NB), .NUM_CARS(NC), .POS_W(POS_W), .FRAC_W(FRAC_W),
    .RAD_W(RAD_W), .FRAME_RATE(FR), .REGEN_SEC(RS), .ITEM_W(IW)
  ) dut (
    .i_render_clk(clk), .i_rst_n(rst_n),
    .i_car_x(car_x), .i_car_y(car_y), .i_car_r(car_r),
    .i_blk_x(blk_x), .i_blk_y(blk_y), .i_blk_r(blk_r),
    .i_item_ready(ready),
    .o_display(o_display), .o_item_valid(o_item_valid),
    .o_item_code(o_item_code), .o_pickup(o_pickup)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  int m_remain [NB];   // frames still hidden (0 = shown)
  bit m_pick   [NB];
  bit m_valid  [NC];
  int m_code   [NC];
  int m_rr;
  int m_lfsr;

  int n_vec = 0;
  int n_err = 0;

  function automatic longint sx(input logic [POS_W-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic bit model_hit(int b, int c);
    longint dx, dy, rs;
    dx = sx(car_x[c*POS_W +: POS_W]) - sx(blk_x[b*POS_W +: POS_W]);
    dy = sx(car_y[c*POS_W +: POS_W]) - sx(blk_y[b*POS_W +: POS_W]);
    rs = (longint'(car_r[c*RAD_W +: RAD_W]) + longint'(blk_r[b*RAD_W +: RAD_W])) * (1 << FRAC_W);
    return (dx*dx + dy*dy) <= rs*rs;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NB; b++) begin m_remain[b] = 0; m_pick[b] = 0; end
    for (int c = 0; c < NC; c++) begin m_valid[c] = 0; m_code[c] = 0; end
    m_rr = 0;
    m_lfsr = 'hA5;
  endtask

  // One frame of game rules, evaluated with the inputs the DUT samples.
  task automatic model_step();
    bit won [NC];
    bit shown [NB];
    int nrr, c;
    nrr = m_rr;
    for (int i = 0; i < NC; i++) won[i] = 0;
    for (int b = 0; b < NB; b++) begin
      shown[b] = (m_remain[b] == 0);
      m_pick[b] = 0;
      if (!shown[b]) m_remain[b]--;
    end
    for (int b = 0; b < NB; b++) begin
      if (shown[b]) begin
        for (int k = 0; k < NC; k++) begin
          c = (m_rr + k) % NC;
          if (!m_pick[b] && model_hit(b, c) && (!m_valid[c] || ready[c]) && !won[c]) begin
            won[c] = 1; m_pick[b] = 1; m_remain[b] = HIDE; nrr = (c + 1) % NC;
          end
        end
      end
    end
    for (int i = 0; i < NC; i++) begin
      if (won[i]) begin m_valid[i] = 1; m_code[i] = m_lfsr % (1 << IW); end
      else if (ready[i]) m_valid[i] = 0;
    end
    m_rr = nrr;
    m_lfsr = (m_lfsr & 1) ? ((m_lfsr >> 1) ^ 'hB8) : (m_lfsr >> 1);
  endtask

  function automatic bit exp_disp(int b);
    if (m_remain[b] == 0) return 1'b1;
`ifdef QBLOCK_RESPAWN_BLINK_EN
    begin
      int el;
      el = HIDE - m_remain[b];
      if (el >= HIDE - FR) return el[3];
    end
`endif
    return 1'b0;
  endfunction

  function automatic logic [VEC_W-1:0] exp_vec();
    logic [NB-1:0] d, p;
    logic [NC-1:0] v;
    logic [NC*IW-1:0] cd;
    int code;
    for (int b = 0; b < NB; b++) begin d[b] = exp_disp(b); p[b] = m_pick[b]; end
    for (int c = 0; c < NC; c++) begin
      code = m_code[c];
      v[c] = m_valid[c];
      cd[c*IW +: IW] = code[IW-1:0];
    end
    return {d, p, v, cd};
  endfunction

  function automatic logic [VEC_W-1:0] dut_vec();
    return {o_display, o_pickup, o_item_valid, o_item_code};
  endfunction

  task automatic adv();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_car(int c, int x, int y, int r);
    car_x[c*POS_W +: POS_W] = x[POS_W-1:0];
    car_y[c*POS_W +: POS_W] = y[POS_W-1:0];
    car_r[c*RAD_W +: RAD_W] = r[RAD_W-1:0];
  endtask

  task automatic set_blk(int b, int x, int y, int r);
    blk_x[b*POS_W +: POS_W] = x[POS_W-1:0];
    blk_y[b*POS_W +: POS_W] = y[POS_W-1:0];
    blk_r[b*RAD_W +: RAD_W] = r[RAD_W-1:0];
  endtask

  task automatic park();
    for (int b = 0; b < NB; b++) set_blk(b, (-1500 + 700*b) * 16, 0, 2);
    for (int c = 0; c < NC; c++) set_car(c, 1800 * 16, (1800 - 3600*c) * 16, 3);
  endtask

  task automatic test_reset();
    ready = '0;
    park();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 model_reset();
    n_vec++; if (o_display !== '1) begin n_err++; $display("FAIL reset_display: got %b want %b", o_display, {NB{1'b1}}); end
    n_vec++; if (o_pickup !== '0) begin n_err++; $display("FAIL reset_pickup: got %b want 0", o_pickup); end
    n_vec++; if (o_item_valid !== '0) begin n_err++; $display("FAIL reset_valid: got %b want 0", o_item_valid); end
    n_vec++; if (o_item_code !== '0) begin n_err++; $display("FAIL reset_code: got %h want 0", o_item_code); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_pickup();
    int low_cnt, exp_code;
    set_car(0, 100*16, 100*16, 3);
    set_blk(0, 104*16, 100*16, 2);
    adv();
    n_vec++; if (dut_vec() !== exp_vec()) begin n_err++; $display("FAIL single_model: got %h want %h", dut_vec(), exp_vec()); end
    n_vec++; if (o_pickup[0] !== 1'b1 || o_item_valid[0] !== 1'b1 || o_display[0] !== 1'b0) begin
      n_err++; $display("FAIL single_hit: pickup=%b valid=%b display=%b want 1 1 0", o_pickup[0], o_item_valid[0], o_display[0]);
    end
    low_cnt = 1;
    for (int i = 0; i < HIDE + 20 && m_remain[0] != 0; i++) begin
      adv();
      n_vec++; if (dut_vec() !== exp_vec()) begin n_err++; $display("FAIL single_hide: got %h want %h", dut_vec(), exp_vec()); end
      if (o_display[0] === 1'b0) low_cnt++;
    end
    n_vec++; if (o_display[0] !== 1'b1) begin n_err++; $display("FAIL single_respawn: display=%b want 1", o_display[0]); end
`ifndef QBLOCK_RESPAWN_BLINK_EN
    n_vec++; if (low_cnt != HIDE) begin n_err++; $display("FAIL single_hide_len: got %0d want %0d", low_cnt, HIDE); end
`endif
    // Car still overlaps: consume and regrab on the same edge.
    ready[0] = 1'b1;
    exp_code = m_lfsr % (1 << IW);
    adv();
    n_vec++; if (dut_vec() !== exp_vec()) begin n_err++; $display("FAIL b2b_model: got %h want %h", dut_vec(), exp_vec()); end
    n_vec++; if (o_item_valid[0] !== 1'b1 || o_pickup[0] !== 1'b1 || o_item_code[IW-1:0] !== exp_code[IW-1:0]) begin
      n_err++; $display("FAIL b2b_regrab: valid=%b pickup=%b code=%0d want 1 1 %0d", o_item_valid[0], o_pickup[0], o_item_code[IW-1:0], exp_code);
    end
    ready = '0;
    park();
    ready[0] = 1'b1;
    adv();
    ready = '0;
    n_vec++; if (dut_vec() !== exp_vec()) begin n_err++; $display("FAIL single_consume: got %h want %h", dut_vec(), exp_vec()); end
  endtask

  task automatic test_tangency();
    set_car(0, -800*16 + 80, 0, 3);   // dx = 5.0, radius sum 5
    adv();
    n_vec++; if (o_pickup[1] !== 1'b1) begin n_err++; $display("FAIL tangent_hit: pickup=%b want 1", o_pickup[1]); end
    park();
    ready[0] = 1'b1;
    adv();
    ready = '0;
    set_car(0, -100*16 + 81, 0, 3);   // one LSB beyond tangency
    repeat (4) begin
      adv();
      n_vec++; if (o_display[2] !== 1'b1 || o_pickup[2] !== 1'b0 || dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL tangent_plus_lsb: got %h want %h", dut_vec(), exp_vec());
      end
    end
    set_car(0, -100*16, -80, 3);      // tangency along y
    adv();
    n_vec++; if (o_pickup[2] !== 1'b1 || dut_vec() !== exp_vec()) begin n_err++; $display("FAIL tangent_y: got %h want %h", dut_vec(), exp_vec()); end
    park();
    ready[0] = 1'b1;
    adv();
    ready = '0;
  endtask

  task automatic test_contention();
    bit found;
    #2 rst_n = 1'b0;
    #1 model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    park();
    set_car(0, 600*16, 0, 3);
    set_car(1, 600*16, 0, 3);
    adv();
    n_vec++; if (o_pickup[3] !== 1'b1 || o_item_valid !== 2'b01 || dut_vec() !== exp_vec()) begin
      n_err++; $display("FAIL contend_first: pickup=%b valid=%b want pickup[3]=1 valid=01", o_pickup, o_item_valid);
    end
    ready = 2'b01;
    adv();
    ready = '0;
    found = 0;
    for (int i = 0; i < HIDE + 10 && !found; i++) begin
      adv();
      n_vec++; if (dut_vec() !== exp_vec()) begin n_err++; $display("FAIL contend_wait: got %h want %h", dut_vec(), exp_vec()); end
      if (o_pickup[3] === 1'b1) found = 1;
    end
    n_vec++; if (!found || o_item_valid !== 2'b10) begin
      n_err++; $display("FAIL contend_rr: found=%0d valid=%b want found=1 valid=10", found, o_item_valid);
    end
    park();
    ready = 2'b10;
    adv();
    ready = '0;
  endtask

  task automatic test_pending();
    int exp_code;
    set_car(0, -1500*16, 0, 3);
    adv();
    n_vec++; if (o_item_valid[0] !== 1'b1 || dut_vec() !== exp_vec()) begin n_err++; $display("FAIL pending_setup: valid=%b want 1", o_item_valid[0]); end
    set_car(0, -800*16 + 16, 0, 3);
    repeat (5) begin
      adv();
      n_vec++; if (o_display[1] !== 1'b1 || o_pickup[1] !== 1'b0 || dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL pending_blocks: display=%b pickup=%b want 1 0", o_display[1], o_pickup[1]);
      end
    end
    ready[0] = 1'b1;
    exp_code = m_lfsr % (1 << IW);
    adv();
    ready = '0;
    n_vec++; if (o_pickup[1] !== 1'b1 || o_item_valid[0] !== 1'b1 || o_item_code[IW-1:0] !== exp_code[IW-1:0]) begin
      n_err++; $display("FAIL ready_and_grant: pickup=%b valid=%b code=%0d want 1 1 %0d", o_pickup[1], o_item_valid[0], o_item_code[IW-1:0], exp_code);
    end
  endtask

  task automatic test_reset_mid_hide();
    park();
    repeat (50) begin
      adv();
      n_vec++; if (dut_vec() !== exp_vec()) begin n_err++; $display("FAIL midhide_run: got %h want %h", dut_vec(), exp_vec()); end
    end
    n_vec++; if (o_display[1] !== 1'b0 || o_item_valid[0] !== 1'b1) begin
      n_err++; $display("FAIL midhide_pre: display=%b valid=%b want 0 1", o_display[1], o_item_valid[0]);
    end
    #2 rst_n = 1'b0;
    #1 model_reset();
    n_vec++; if (dut_vec() !== {{NB{1'b1}}, {(VEC_W-NB){1'b0}}}) begin
      n_err++; $display("FAIL midhide_reset: got %h want %h", dut_vec(), {{NB{1'b1}}, {(VEC_W-NB){1'b0}}});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    int b, dx, dy;
    park();
    for (int i = 0; i < NB; i++) blk_r[i*RAD_W +: RAD_W] = RAD_W'(1 + $urandom_range(3));
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(3) == 0) begin
        for (int c = 0; c < NC; c++) begin
          b  = int'($urandom_range(NB-1));
          dx = int'($urandom_range(300)) - 150;
          dy = int'($urandom_range(300)) - 150;
          if ($urandom_range(4) == 0) set_car(c, 1800*16, (1800 - 3600*c) * 16, 3);
          else set_car(c, int'(sx(blk_x[b*POS_W +: POS_W])) + dx,
                          int'(sx(blk_y[b*POS_W +: POS_W])) + dy, 1 + int'($urandom_range(3)));
        end
      end
      for (int c = 0; c < NC; c++) ready[c] = ($urandom_range(2) == 0);
      adv();
      n_vec++; if (dut_vec() !== exp_vec()) begin n_err++; $display("FAIL random_%0d: got %h want %h", n, dut_vec(), exp_vec()); end
    end
    ready = '0;
  endtask

  initial begin
    test_reset();
    test_single_pickup();
    test_tangency();
    test_contention();
    test_pending();
    test_reset_mid_hide();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
